// File: rtl/tt_sweep_pkg.sv
// Shared types and width helpers for the truth-table sweep checker.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Vector index carries one extra bit so the terminal test never aliases on wrap.
   function automatic int vec_w(input int n_in);
      return n_in + 1;
   endfunction

   // Hold timer width; a one-cycle hold still needs a 1-bit counter.
   function automatic int hold_w(input int hold);
      return (hold <= 2) ? 1 : $clog2(hold);
   endfunction

endpackage

// File: rtl/tt_sweep_checker_hold_timer.sv
// Hold-window timer: counts 0..HOLD-1 while enabled and flags the last cycle.
module hold_timer
   import tt_sweep_pkg::*;
#(
   parameter int HOLD = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int            HW       = hold_w(HOLD);
   localparam logic [HW-1:0] LAST_CNT = HW'(HOLD - 1);

   logic [HW-1:0] cnt_q;
   logic [HW-1:0] cnt_d;

   assign last = (cnt_q == LAST_CNT);

   // Next count: clear wins, otherwise wrap to zero after the last hold cycle.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = last ? '0 : cnt_q + HW'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every input vector, samples the DUT
// at the end of each hold window and counts mismatches against EXPECTED.
module tt_sweep_checker
   import tt_sweep_pkg::*;
#(
   parameter int                   N_IN     = 3,
   parameter int                   HOLD     = 10,
   parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'b1110_1000,
   parameter int                   ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             loop,
   input  logic             dut_f,
   output logic [N_IN-1:0]  stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             sweep_tick,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [N_IN-1:0]  first_err_vec
);

   localparam int            VW       = vec_w(N_IN);
   localparam logic [VW-1:0] LAST_VEC = VW'((1 << N_IN) - 1);

   state_t           state_q, state_d;
   logic [VW-1:0]    vec_q, vec_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             fev_q, fev_d;
   logic [N_IN-1:0]  fvec_q, fvec_d;
   logic             tick_q, tick_d;

   logic timer_clr;
   logic timer_en;
   logic timer_last;
   logic mismatch;

   hold_timer #(
      .HOLD (HOLD)
   ) u_hold_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (timer_clr),
      .en    (timer_en),
      .last  (timer_last)
   );

   assign mismatch = (dut_f != EXPECTED[vec_q[N_IN-1:0]]);

   // Next-state logic: sweep sequencing, sampling, error counting and first-error capture.
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      err_d     = err_q;
      fev_d     = fev_q;
      fvec_d    = fvec_q;
      tick_d    = 1'b0;
      timer_clr = 1'b0;
      timer_en  = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = APPLY;
               vec_d     = '0;
               err_d     = '0;
               fev_d     = 1'b0;
               fvec_d    = '0;
               timer_clr = 1'b1;
            end
         end
         APPLY: begin
            timer_en = 1'b1;
            if (timer_last) begin
               if (mismatch) begin
                  if (err_q != '1) begin
                     err_d = err_q + ERR_W'(1);
                  end
                  if (!fev_q) begin
                     fev_d  = 1'b1;
                     fvec_d = vec_q[N_IN-1:0];
                  end
               end
               if (vec_q == LAST_VEC) begin
                  tick_d = 1'b1;
                  if (loop) begin
                     vec_d = '0;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  vec_d = vec_q + VW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any sweep silently.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fvec_q  <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         fev_q   <= fev_d;
         fvec_q  <= fvec_d;
         tick_q  <= tick_d;
      end
   end

   assign stim            = vec_q[N_IN-1:0];
   assign busy            = (state_q == APPLY);
   assign done            = (state_q == DONE);
   assign pass            = (state_q == DONE) && (err_q == '0);
   assign sweep_tick      = tick_q;
   assign err_count       = err_q;
   assign first_err_valid = fev_q;
   assign first_err_vec   = fvec_q;

endmodule

// File: doc/tt_sweep_checker.md
# tt_sweep_checker

Synthesisable exhaustive truth-table sweeper and checker for an N-input, 1-output combinational block under test. It drives every input vector in binary order, holds each for a programmable number of cycles, and samples the DUT output at the end of each hold window. The sample is compared against a parametrised expected truth table, and mismatches are counted. It sits beside a combinational DUT on the FPGA or in simulation, replacing hand-written per-vector stimulus with a one-shot or continuous on-chip self-check.

## Interface
- `N_IN`, 3: number of DUT inputs; sweep length is 2^N_IN vectors.
- `HOLD`, 10: clock cycles each vector is held; must be ≥1.
- `EXPECTED`, 8'b1110_1000: expected truth table, 2^N_IN bits; bit v is the expected output for vector v. The default is 3-input majority.
- `ERR_W`, 8: width of the error counter.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a sweep; honoured only in IDLE or DONE.
- `loop`  in  1  continuous mode; sampled at each sweep end.
- `dut_f`  in  1  DUT output.
- `stim`  out  N_IN  DUT input vector; `stim[N_IN-1]` is the MSB.
- `busy`  out  1  sweep in progress.
- `done`  out  1  level; high in DONE.
- `pass`  out  1  level; `done && err_count==0`.
- `sweep_tick`  out  1  one-cycle pulse at each sweep end.
- `err_count`  out  ERR_W  mismatch count; saturates at all-ones.
- `first_err_valid`  out  1  at least one mismatch since start.
- `first_err_vec`  out  N_IN  vector of the first mismatch.

## Operation
- **States:** IDLE, APPLY, DONE.
- **Reset:** with `rst_n`=0 at an edge, the next state is IDLE. All outputs go to 0: `stim`, `busy`, `done`, `pass`, `sweep_tick`, `err_count`, `first_err_valid`, `first_err_vec`. The vector index and hold timer are cleared. Reset mid-sweep aborts the sweep without a `sweep_tick`.
- **IDLE or DONE, `start`=1:** go to APPLY. In the same edge: vector index 0, `stim`=0, hold timer 0, `err_count`=0, `first_err_valid`=0, `first_err_vec`=0, `done`=0, `busy`=1.
- **APPLY, each hold window:** the hold timer counts 0..HOLD-1. At the edge where the timer equals HOLD-1:
  - Compare `dut_f` (the value during the last hold cycle) with `EXPECTED[v]`.
  - On mismatch, increment `err_count` (saturating).
  - On the first mismatch, set `first_err_valid`=1 and `first_err_vec`=v.
  - Advance to v+1, with `stim`=v+1, and reset the timer.
- **Last vector (v = 2^N_IN−1), at its sample edge:**
  - `sweep_tick`=1 for one cycle.
  - If `loop`=1: wrap to v=0 and stay in APPLY. `err_count`, `first_err_*` accumulate and are not cleared.
  - If `loop`=0: go to DONE, `busy`=0, `done`=1. `stim` holds the last vector.
- **`start` while in APPLY** is ignored.
- **`start` and the sweep end on the same edge:** the sweep ends normally; the `start` is ignored.
- **Final mismatch and transition to DONE on the same edge:** the final mismatch is included in `err_count` and `pass`.
- **Width:** the vector index is N_IN+1 bits internally, so the terminal test does not alias on wrap.

## Timing
- Let t0 be the edge that accepts `start`.
- Vector v is driven from edge t0+v·HOLD and sampled at edge t0+(v+1)·HOLD.
- The sweep ends at edge t0+2^N_IN·HOLD. After that edge, `done`/`pass` are valid and `sweep_tick` is high for exactly that cycle.
- `busy` rises at t0 and falls at the sweep-end edge when not looping.
- All outputs are registered; there are no combinational paths from any input to any output.
- The DUT path must settle within HOLD cycles minus setup. HOLD=1 allows a single-cycle combinational path.

## Structure
- **Package `tt_sweep_pkg`:**
  - `state_t` enum (IDLE, APPLY, DONE).
  - Functions `vec_w(N_IN)` = N_IN+1 and `hold_w(HOLD)` = $clog2(HOLD) (minimum 1).
- **Sub-module `hold_timer`:** parametrised HOLD.
  - Inputs: `clr`, `en`.
  - Output: `last`, asserted when the count equals HOLD-1.
  - Synchronous active-low reset.
- **Top:** the FSM, the vector counter, and the compare/count datapath.

## Test plan
- **Correct DUT.** Defaults, DUT = majority, `start` pulse at t0.
  - `stim` steps 0..7 every 10 cycles.
  - At t0+80: `done`=1, `pass`=1, `err_count`=0, `sweep_tick` pulse, `busy`=0.
- **DUT tied to 0.** Defaults.
  - `err_count`=4, `first_err_valid`=1, `first_err_vec`=3, `pass`=0 at t0+80.
- **Ignored start.** `start` re-pulsed at t0+35.
  - Ignored: `done` still at t0+80, `err_count` unchanged.
  - A subsequent `start` in DONE restarts with counters cleared.
- **Reset mid-sweep.** `rst_n`=0 for one edge at t0+45 (vector 4).
  - Next cycle: all outputs 0, state IDLE, no `sweep_tick`.
  - No further activity until `start`.
- **Loop mode.** `loop`=1, DUT tied to 1.
  - `sweep_tick` at t0+80, t0+160 and t0+240.
  - `err_count` reads 4, 8 and 12; `first_err_vec`=0 throughout.
  - Drop `loop` before t0+240: `done`=1 at t0+240.
  - With `ERR_W`=3, `err_count` saturates at 7.
- **Alternate parameters.** `N_IN`=4, `HOLD`=1, `EXPECTED`=16'h6996 (4-input XOR), correct DUT.
  - `done`=1 and `pass`=1 at t0+16.
  - Injecting a fault at vector 9 gives `first_err_vec`=9 and `err_count`=1.
